issue_queue_rs: RTL
===================

// Module: issue_queue_rs
// PURPOSE
//   Parametrised reservation station / issue queue for one functional-unit class.
//   Sits between the dispatch pipeline buffer and the FU.
//   Holds up to DEPTH renamed µops and snoops NUM_WB writeback tag buses to wake up sources.
//   Issues the oldest entry whose sources are both ready, one per cycle; supports full pipeline flush.
// PARAMETERS
//   DEPTH      8   entries (power of 2, >=2); AGE_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)
//   PREG_W     8   physical register tag width; tag 0 is hardwired ready
//   ROB_W      4   ROB index width
//   IMM_W      32  immediate width
//   OPC_W      7   opcode width
//   NUM_WB     2   number of writeback/wakeup broadcast ports
// PORTS
//   clk             in   1              clock, all state on posedge
//   reset           in   1              synchronous, active-high
//   valid_in        in   1              dispatch µop valid
//   ready_in        out  1              RS can accept (count < DEPTH)
//   in_opcode       in   OPC_W          dispatch opcode
//   in_prd          in   PREG_W         destination preg
//   in_pr1/in_pr2   in   PREG_W         source pregs
//   in_pr1_rdy/in_pr2_rdy in 1          source ready at rename
//   in_imm          in   IMM_W          immediate
//   in_rob_index    in   ROB_W          ROB slot
//   wb_valid        in   NUM_WB         wakeup broadcast valid per port
//   wb_tag          in   NUM_WB*PREG_W  wakeup tags, port i at [i*PREG_W +: PREG_W]
//   flush           in   1              discard all entries
//   ready_out       in   1              FU accepts issue
//   valid_out       out  1              issue candidate present
//   out_opcode/out_prd/out_pr1/out_pr2/out_imm/out_rob_index  out  as inputs  issued µop
//   count           out  CNT_W          occupied entries
// BEHAVIOUR
//   Entry: valid, fields, pr1_rdy, pr2_rdy, age[AGE_W].
//   age = number of valid entries younger than this one; valid ages are unique in 0..count-1.
//   Dispatch: accepted when valid_in && ready_in && !flush.
//     Written into the lowest-index free entry with age 0.
//     Every other valid entry does age+1.
//     A source with tag 0 is stored ready.
//   ready_in = (count != DEPTH); registered-count based, no credit for a same-cycle issue.
//   Wakeup: each cycle, for every valid entry and every port i:
//     if wb_valid[i] && wb_tag[i]==prX, set prX_rdy (visible next cycle).
//     Multiple matching ports are harmless.
//   Select (combinational):
//     eligible = valid && pr1_rdy && pr2_rdy.
//     Pick the eligible entry with the max age.
//     valid_out = any eligible; out_* = selected entry's fields.
//     out_* are don't-care when valid_out=0; drive entry 0.
//   Issue: valid_out && ready_out frees the selected entry.
//     Entries with age > issued age do age-1.
//   Same-cycle dispatch+issue: older-than-issued entries keep their age; others +1; new entry age 0.
//   Latency: dispatch -> earliest issue = 1 cycle (ready sources).
//   Latency: wakeup broadcast -> issue eligibility = 1 cycle.
//   Full (count==DEPTH): ready_in=0; issue still allowed; ready_in rises the cycle after an issue.
//   Empty: valid_out=0.
//   count update: +1 on dispatch, -1 on issue, unchanged on both.
//   flush: all entries invalid next cycle, count=0; dispatch and issue in the flush cycle are dropped (no handshake effects).
//   Reset (any cycle, overrides flush): all entries invalid, ages 0, count=0, valid_out=0, ready_in=1.
// CONFIGURATION
//   RS_DISPATCH_WAKEUP_EN
//     defined: the dispatching µop's sources are also compared against same-cycle wb_valid/wb_tag and stored ready on a match.
//     undefined: in_pr*_rdy stored as given; upstream rename must fold same-cycle writeback into the ready bits.
// TESTING
//   1 Reset, then idle -> valid_out=0, ready_in=1, count=0.
//   2 Dispatch A(pr1=5,pr2=0,rdy=1,1), ready_out=1 -> A issues the next cycle; count 1->0.
//   3 Dispatch A(pr1=9 not rdy), then B(all rdy), then wb_tag=9 -> B issues first; A issues 1 cycle after the wakeup.
//   4 Dispatch C,D,E all rdy with ready_out=0, then ready_out=1 -> issue order C,D,E (oldest first).
//   5 Fill 8 entries not rdy -> ready_in=0, extra valid_in ignored; wake one, issue -> ready_in=1 the next cycle.
//   6 flush with 4 entries plus a same-cycle dispatch -> count=0, valid_out=0 the next cycle, nothing issued.
//   7 Macro on: dispatch pr1=12 not rdy while wb_tag=12 -> issues the next cycle.
//     Macro off: stalls until a later wakeup.

Source files
------------

// File: rtl/issue_queue_rs.sv
// issue_queue_rs: reservation station holding DEPTH renamed uops, waking sources from NUM_WB tag buses and issuing the oldest ready entry each cycle.
// Ports: clk/reset (sync active-high); valid_in/ready_in + in_* dispatch; wb_valid/wb_tag wakeup; flush;
//   ready_out/valid_out + out_* issue; count occupancy. Optional RS_DISPATCH_WAKEUP_EN: dispatch sources also snoop same-cycle wakeups.
module issue_queue_rs #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 8,
  parameter int ROB_W  = 4,
  parameter int IMM_W  = 32,
  parameter int OPC_W  = 7,
  parameter int NUM_WB = 2,
  parameter int AGE_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic [OPC_W-1:0]         in_opcode,
  input  logic [PREG_W-1:0]        in_prd,
  input  logic [PREG_W-1:0]        in_pr1,
  input  logic [PREG_W-1:0]        in_pr2,
  input  logic                     in_pr1_rdy,
  input  logic                     in_pr2_rdy,
  input  logic [IMM_W-1:0]         in_imm,
  input  logic [ROB_W-1:0]         in_rob_index,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PREG_W-1:0] wb_tag,
  input  logic                     flush,
  input  logic                     ready_out,
  output logic                     valid_out,
  output logic [OPC_W-1:0]         out_opcode,
  output logic [PREG_W-1:0]        out_prd,
  output logic [PREG_W-1:0]        out_pr1,
  output logic [PREG_W-1:0]        out_pr2,
  output logic [IMM_W-1:0]         out_imm,
  output logic [ROB_W-1:0]         out_rob_index,
  output logic [CNT_W-1:0]         count
);
  logic [DEPTH-1:0]  vld, r1, r2;
  logic [OPC_W-1:0]  opc [DEPTH];
  logic [PREG_W-1:0] prd [DEPTH];
  logic [PREG_W-1:0] p1 [DEPTH];
  logic [PREG_W-1:0] p2 [DEPTH];
  logic [IMM_W-1:0]  imm [DEPTH];
  logic [ROB_W-1:0]  rob [DEPTH];
  logic [AGE_W-1:0]  age [DEPTH];
  logic [AGE_W-1:0]  sel, sel_age, free;
  logic              found, disp, iss, n1, n2;

  function automatic logic hit(input logic [PREG_W-1:0] t, input logic [NUM_WB-1:0] v,
                               input logic [NUM_WB*PREG_W-1:0] tags);
    logic h;
    h = 1'b0;
    for (int k = 0; k < NUM_WB; k++)
      h = h | (v[k] && tags[k*PREG_W +: PREG_W] == t);
    return h;
  endfunction

  always_comb begin
    sel = '0;
    sel_age = '0;
    found = 1'b0;
    free = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!vld[i]) free = AGE_W'(i);
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && r1[i] && r2[i] && (!found || age[i] > sel_age)) begin
        found = 1'b1;
        sel = AGE_W'(i);
        sel_age = age[i];
      end
  end

  assign ready_in  = count != CNT_W'(DEPTH);
  assign valid_out = found;
  assign disp      = valid_in && ready_in && !flush;
  assign iss       = found && ready_out && !flush;

`ifdef RS_DISPATCH_WAKEUP_EN
  assign n1 = in_pr1_rdy || in_pr1 == '0 || hit(in_pr1, wb_valid, wb_tag);
  assign n2 = in_pr2_rdy || in_pr2 == '0 || hit(in_pr2, wb_valid, wb_tag);
`else
  assign n1 = in_pr1_rdy || in_pr1 == '0;
  assign n2 = in_pr2_rdy || in_pr2 == '0;
`endif

  assign out_opcode    = opc[sel];
  assign out_prd       = prd[sel];
  assign out_pr1       = p1[sel];
  assign out_pr2       = p2[sel];
  assign out_imm       = imm[sel];
  assign out_rob_index = rob[sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (flush) begin
      vld <= '0;
      count <= '0;
    end else begin
      count <= count + CNT_W'(disp) - CNT_W'(iss);
      for (int i = 0; i < DEPTH; i++) begin
        r1[i] <= r1[i] | hit(p1[i], wb_valid, wb_tag);
        r2[i] <= r2[i] | hit(p2[i], wb_valid, wb_tag);
        // entries older than the issued one close the gap unless a dispatch refills it
        if (vld[i])
          age[i] <= (iss && age[i] > sel_age) ? age[i] - AGE_W'(!disp) : age[i] + AGE_W'(disp);
        if (iss && sel == AGE_W'(i)) vld[i] <= 1'b0;
        if (disp && free == AGE_W'(i)) begin
          vld[i] <= 1'b1;
          age[i] <= '0;
          opc[i] <= in_opcode;
          prd[i] <= in_prd;
          p1[i]  <= in_pr1;
          p2[i]  <= in_pr2;
          imm[i] <= in_imm;
          rob[i] <= in_rob_index;
          r1[i]  <= n1;
          r2[i]  <= n2;
        end
      end
    end
  end
endmodule
